// File: rtl/ttc_interrupt_ctrl24_pkg.sv
// ttc_intr_pkg24: shared constants for the ttc_interrupt_ctrl24 slice.
//   NUM_SRC_D / DATA_W_D / COAL_W_D : default widths
//   MODE_EDGE / MODE_LEVEL          : per-source mode register encoding
package ttc_intr_pkg24;
  localparam int NUM_SRC_D = 6;
  localparam int DATA_W_D  = 16;
  localparam int COAL_W_D  = 8;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;
endpackage

// File: rtl/ttc_interrupt_ctrl24_if.sv
// ttc_interrupt_ctrl24_if: APB-style register write bus.
//   pwdata24       write data
//   en_reg_sel24   load enable register
//   mode_reg_sel24 load mode register
//   clr_reg_sel24  write-1-to-clear status
//   coal_reg_sel24 load hold-off register (coalescing build only)
// Modports: master drives the bus, slave (the controller) receives it.
interface ttc_interrupt_ctrl24_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pwdata24;
  logic              en_reg_sel24;
  logic              mode_reg_sel24;
  logic              clr_reg_sel24;
  logic              coal_reg_sel24;

  modport master (output pwdata24, en_reg_sel24, mode_reg_sel24,
                         clr_reg_sel24, coal_reg_sel24);
  modport slave  (input  pwdata24, en_reg_sel24, mode_reg_sel24,
                         clr_reg_sel24, coal_reg_sel24);
endinterface

// File: rtl/ttc_interrupt_ctrl24_evt_det.sv
// ttc_intr_evt_det24: two-stage source sampler plus per-bit event detect.
//   pclk24, n_p_reset24 : clock, async active-low reset
//   src_i               : raw sources (pclk24-synchronous)
//   mode_i              : 1 = level, 0 = rising edge
//   evt_o               : per-source event, combinational from the samplers
module ttc_intr_evt_det24
  import ttc_intr_pkg24::*;
#(
  parameter int NUM_SRC = NUM_SRC_D
) (
  input  logic               pclk24,
  input  logic               n_p_reset24,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mode_i,
  output logic [NUM_SRC-1:0] evt_o
);
  logic [NUM_SRC-1:0] src_q, src_qq;

  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      src_q  <= '0;
      src_qq <= '0;
    end else begin
      src_q  <= src_i;
      src_qq <= src_q;
    end
  end

  // Edge detection compares the two sample stages, so a mode switch on a
  // source that is already high never produces a spurious edge.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_evt
    assign evt_o[i] = (mode_i[i] == MODE_LEVEL) ? src_q[i]
                                                : (src_q[i] & ~src_qq[i]);
  end
endmodule

// File: rtl/ttc_interrupt_ctrl24.sv
// ttc_interrupt_ctrl24: interrupt aggregator with W1C status, enable/mode
// registers and a registered interrupt output.
//   pclk24, n_p_reset24 : clock, async active-low reset
//   bus                 : register write bus (slave modport)
//   intr_src24          : raw interrupt sources
//   interrupt24         : registered interrupt request
//   intr_*_out24        : status / enable / mode / pending (status & enable)
//   coal_out24          : hold-off register, zero unless coalescing is built
// Optional feature macro: TTC_INTR_COALESCE_EN (hold-off coalescing timer).
module ttc_interrupt_ctrl24
  import ttc_intr_pkg24::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int COAL_W  = COAL_W_D
) (
  input  logic                   pclk24,
  input  logic                   n_p_reset24,
  ttc_interrupt_ctrl24_if.slave  bus,
  input  logic [NUM_SRC-1:0]     intr_src24,
  output logic                   interrupt24,
  output logic [NUM_SRC-1:0]     intr_status_out24,
  output logic [NUM_SRC-1:0]     intr_en_out24,
  output logic [NUM_SRC-1:0]     intr_mode_out24,
  output logic [NUM_SRC-1:0]     intr_pend_out24,
  output logic [COAL_W-1:0]      coal_out24
);
  logic [NUM_SRC-1:0] en_q, mode_q, stat_q, stat_d, evt, clr_mask, pend;
  logic               int_q, int_d;

  ttc_intr_evt_det24 #(.NUM_SRC(NUM_SRC)) u_evt (
    .pclk24      (pclk24),
    .n_p_reset24 (n_p_reset24),
    .src_i       (intr_src24),
    .mode_i      (mode_q),
    .evt_o       (evt)
  );

  // Set is OR-ed in after the clear so a same-cycle event wins.
  always_comb begin
    clr_mask = bus.clr_reg_sel24 ? bus.pwdata24[NUM_SRC-1:0] : '0;
    stat_d   = (stat_q & ~clr_mask) | (evt & en_q);
    pend     = stat_q & en_q;
  end

  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      en_q   <= '0;
      mode_q <= '0;
      stat_q <= '0;
      int_q  <= 1'b0;
    end else begin
      if (bus.en_reg_sel24)   en_q   <= bus.pwdata24[NUM_SRC-1:0];
      if (bus.mode_reg_sel24) mode_q <= bus.pwdata24[NUM_SRC-1:0];
      stat_q <= stat_d;
      int_q  <= int_d;
    end
  end

`ifdef TTC_INTR_COALESCE_EN
  logic [COAL_W-1:0] hold_q, tmr_q, tmr_d;

  // Timer saturates at the hold-off value; comparing the next timer value
  // makes hold-off 0 behave exactly like the uncoalesced path and makes a
  // lowered hold-off assert on the following edge.
  always_comb begin
    if (pend == '0)          tmr_d = '0;
    else if (tmr_q >= hold_q) tmr_d = hold_q;
    else                     tmr_d = tmr_q + 1'b1;
    int_d = (pend != '0) && (tmr_d == hold_q);
  end

  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      hold_q <= '0;
      tmr_q  <= '0;
    end else begin
      if (bus.coal_reg_sel24) hold_q <= bus.pwdata24[COAL_W-1:0];
      tmr_q <= tmr_d;
    end
  end

  assign coal_out24 = hold_q;
`else
  always_comb int_d = |pend;
  assign coal_out24 = '0;

  logic unused_coal;
  assign unused_coal = bus.coal_reg_sel24;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.pwdata24;

  assign interrupt24       = int_q;
  assign intr_status_out24 = stat_q;
  assign intr_en_out24     = en_q;
  assign intr_mode_out24   = mode_q;
  assign intr_pend_out24   = pend;
endmodule

// File: tb/tb_ttc_interrupt_ctrl24.sv
// Directed bench for ttc_interrupt_ctrl24 (default NUM_SRC=6, DATA_W=16).
module tb_ttc_interrupt_ctrl24;
  localparam int N  = 6;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          pclk24 = 1'b0;
  logic          n_p_reset24;
  logic [N-1:0]  intr_src24;
  logic          interrupt24;
  logic [N-1:0]  intr_status_out24, intr_en_out24, intr_mode_out24, intr_pend_out24;
  logic [CW-1:0] coal_out24;

  int checks = 0;
  int errors = 0;

  ttc_interrupt_ctrl24_if #(.DATA_W(DW)) bus ();

  ttc_interrupt_ctrl24 #(.NUM_SRC(N), .DATA_W(DW), .COAL_W(CW)) dut (
    .pclk24            (pclk24),
    .n_p_reset24       (n_p_reset24),
    .bus               (bus),
    .intr_src24        (intr_src24),
    .interrupt24       (interrupt24),
    .intr_status_out24 (intr_status_out24),
    .intr_en_out24     (intr_en_out24),
    .intr_mode_out24   (intr_mode_out24),
    .intr_pend_out24   (intr_pend_out24),
    .coal_out24        (coal_out24)
  );

  always #5 pclk24 = ~pclk24;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge pclk24);
    #1;
  endtask

  // sel: 0 enable, 1 mode, 2 clear, 3 hold-off
  task automatic wr(input int sel, input logic [DW-1:0] d);
    bus.pwdata24 = d;
    case (sel)
      0: bus.en_reg_sel24   = 1'b1;
      1: bus.mode_reg_sel24 = 1'b1;
      2: bus.clr_reg_sel24  = 1'b1;
      default: bus.coal_reg_sel24 = 1'b1;
    endcase
    tick();
    bus.en_reg_sel24 = 1'b0; bus.mode_reg_sel24 = 1'b0;
    bus.clr_reg_sel24 = 1'b0; bus.coal_reg_sel24 = 1'b0;
    bus.pwdata24 = '0;
  endtask

  task automatic test_reset();
    n_p_reset24 = 1'b0;
    intr_src24 = '0;
    bus.pwdata24 = '0;
    bus.en_reg_sel24 = 1'b0; bus.mode_reg_sel24 = 1'b0;
    bus.clr_reg_sel24 = 1'b0; bus.coal_reg_sel24 = 1'b0;
    #3;
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL reset_int: got %b exp 0", interrupt24); end
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL reset_status: got %h exp 00", intr_status_out24); end
    checks++; if (intr_en_out24 !== 6'h00) begin errors++; $display("FAIL reset_en: got %h exp 00", intr_en_out24); end
    checks++; if (intr_mode_out24 !== 6'h00) begin errors++; $display("FAIL reset_mode: got %h exp 00", intr_mode_out24); end
    checks++; if (intr_pend_out24 !== 6'h00) begin errors++; $display("FAIL reset_pend: got %h exp 00", intr_pend_out24); end
    checks++; if (coal_out24 !== 8'h00) begin errors++; $display("FAIL reset_coal: got %h exp 00", coal_out24); end
    tick(); tick();
    n_p_reset24 = 1'b1;
    tick();
  endtask

  task automatic test_edge_pulse();
    wr(0, 16'h003F);
    checks++; if (intr_en_out24 !== 6'h3F) begin errors++; $display("FAIL en_write: got %h exp 3f", intr_en_out24); end
    intr_src24 = 6'h04;
    tick();                      // E1: sampled
    intr_src24 = 6'h00;
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL edge_e1_status: got %h exp 00", intr_status_out24); end
    tick();                      // E2: status set
    checks++; if (intr_status_out24 !== 6'h04) begin errors++; $display("FAIL edge_e2_status: got %h exp 04", intr_status_out24); end
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL edge_e2_int: got %b exp 0", interrupt24); end
    tick();                      // E3: interrupt
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL edge_e3_int: got %b exp 1", interrupt24); end
    checks++; if (intr_pend_out24 !== 6'h04) begin errors++; $display("FAIL edge_pend: got %h exp 04", intr_pend_out24); end
    wr(2, 16'h0004);             // Ec
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL clr_status: got %h exp 00", intr_status_out24); end
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL clr_int_ec: got %b exp 1", interrupt24); end
    tick();
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL clr_int_ec1: got %b exp 0", interrupt24); end
  endtask

  task automatic test_level_clear();
    wr(1, 16'h0001);
    intr_src24 = 6'h01;
    tick(); tick();
    checks++; if (intr_status_out24 !== 6'h01) begin errors++; $display("FAIL lvl_set: got %h exp 01", intr_status_out24); end
    bus.pwdata24 = 16'h0001; bus.clr_reg_sel24 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (intr_status_out24[0] !== 1'b1) begin errors++; $display("FAIL lvl_hold_%0d: got %b exp 1", i, intr_status_out24[0]); end
    end
    intr_src24 = 6'h00;
    tick(); tick();
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL lvl_clear: got %h exp 00", intr_status_out24); end
    bus.clr_reg_sel24 = 1'b0; bus.pwdata24 = '0;
    wr(1, 16'h0000);
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL lvl_int_low: got %b exp 0", interrupt24); end
  endtask

  task automatic test_set_wins();
    intr_src24 = 6'h02;
    tick();                      // event visible before next edge
    intr_src24 = 6'h00;
    bus.pwdata24 = 16'h0002; bus.clr_reg_sel24 = 1'b1;
    tick();
    checks++; if (intr_status_out24 !== 6'h02) begin errors++; $display("FAIL set_wins: got %h exp 02", intr_status_out24); end
    tick();
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL set_wins_clr: got %h exp 00", intr_status_out24); end
    bus.clr_reg_sel24 = 1'b0; bus.pwdata24 = '0;
    tick(); tick();
  endtask

  task automatic test_disabled();
    wr(0, 16'h0000);
    intr_src24 = 6'h08;
    tick();
    intr_src24 = 6'h00;
    tick(); tick();
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL dis_status: got %h exp 00", intr_status_out24); end
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL dis_int: got %b exp 0", interrupt24); end
    wr(0, 16'h003F);
    tick();
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL dis_later_status: got %h exp 00", intr_status_out24); end
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL dis_later_int: got %b exp 0", interrupt24); end
  endtask

  task automatic test_enable_pend();
    intr_src24 = 6'h10;
    tick();
    intr_src24 = 6'h00;
    tick(); tick();
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL ep_int: got %b exp 1", interrupt24); end
    wr(0, 16'h0000);
    checks++; if (intr_pend_out24 !== 6'h00) begin errors++; $display("FAIL ep_pend_off: got %h exp 00", intr_pend_out24); end
    tick();
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL ep_int_off: got %b exp 0", interrupt24); end
    checks++; if (intr_status_out24 !== 6'h10) begin errors++; $display("FAIL ep_retain: got %h exp 10", intr_status_out24); end
    wr(0, 16'h003F);             // Ew
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL ep_int_ew: got %b exp 0", interrupt24); end
    checks++; if (intr_pend_out24 !== 6'h10) begin errors++; $display("FAIL ep_pend_on: got %h exp 10", intr_pend_out24); end
    tick();
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL ep_int_ew1: got %b exp 1", interrupt24); end
    wr(2, 16'h003F);
    tick();
  endtask

  task automatic test_multi_sel();
    bus.pwdata24 = 16'h002A;
    bus.en_reg_sel24 = 1'b1; bus.mode_reg_sel24 = 1'b1;
    tick();
    bus.en_reg_sel24 = 1'b0; bus.mode_reg_sel24 = 1'b0; bus.pwdata24 = '0;
    checks++; if (intr_en_out24 !== 6'h2A) begin errors++; $display("FAIL multi_en: got %h exp 2a", intr_en_out24); end
    checks++; if (intr_mode_out24 !== 6'h2A) begin errors++; $display("FAIL multi_mode: got %h exp 2a", intr_mode_out24); end
    wr(0, 16'h003F);
    wr(1, 16'h0000);
  endtask

  task automatic test_mode_change();
    wr(1, 16'h0020);
    intr_src24 = 6'h20;
    tick(); tick();
    checks++; if (intr_status_out24 !== 6'h20) begin errors++; $display("FAIL mc_level: got %h exp 20", intr_status_out24); end
    wr(1, 16'h0000);
    wr(2, 16'h0020);
    tick(); tick();
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL mc_no_edge: got %h exp 00", intr_status_out24); end
    intr_src24 = 6'h00;
    tick(); tick();
  endtask

`ifdef TTC_INTR_COALESCE_EN
  task automatic test_coalesce();
    wr(3, 16'h0004);
    checks++; if (coal_out24 !== 8'h04) begin errors++; $display("FAIL coal_reg: got %h exp 04", coal_out24); end
    intr_src24 = 6'h01;
    tick();                      // E1
    intr_src24 = 6'h00;
    tick();                      // E2: status[0]
    intr_src24 = 6'h20;
    tick();                      // E3
    intr_src24 = 6'h00;
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL coal_e3: got %b exp 0", interrupt24); end
    tick();
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL coal_e4: got %b exp 0", interrupt24); end
    tick();
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL coal_e5: got %b exp 0", interrupt24); end
    tick();
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL coal_e6: got %b exp 1", interrupt24); end
    checks++; if (intr_status_out24 !== 6'h21) begin errors++; $display("FAIL coal_status: got %h exp 21", intr_status_out24); end
  endtask
`endif

  task automatic test_reset_mid();
    intr_src24 = 6'h01;
    tick();
    intr_src24 = 6'h00;
    wr(1, 16'h0015);
`ifdef TTC_INTR_COALESCE_EN
    wr(3, 16'h0000);
`endif
    tick(); tick();
    checks++; if (interrupt24 !== 1'b1) begin errors++; $display("FAIL rm_pre_int: got %b exp 1", interrupt24); end
    n_p_reset24 = 1'b0;
    #1;
    checks++; if (interrupt24 !== 1'b0) begin errors++; $display("FAIL rm_int: got %b exp 0", interrupt24); end
    checks++; if (intr_status_out24 !== 6'h00) begin errors++; $display("FAIL rm_status: got %h exp 00", intr_status_out24); end
    checks++; if (intr_en_out24 !== 6'h00) begin errors++; $display("FAIL rm_en: got %h exp 00", intr_en_out24); end
    checks++; if (intr_mode_out24 !== 6'h00) begin errors++; $display("FAIL rm_mode: got %h exp 00", intr_mode_out24); end
    checks++; if (intr_pend_out24 !== 6'h00) begin errors++; $display("FAIL rm_pend: got %h exp 00", intr_pend_out24); end
    tick();
    n_p_reset24 = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_edge_pulse();
    test_level_clear();
    test_set_wins();
    test_disabled();
    test_enable_pend();
    test_multi_sel();
    test_mode_change();
`ifdef TTC_INTR_COALESCE_EN
    test_coalesce();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
